// File: rtl/ic_pkg.sv
// ic_pkg: shared types and helpers for the icache tag array.
// Optional IC_TAG_PARITY_EN adds an even-parity bit to each tag entry.
package ic_pkg;

  localparam int IC_WAYS  = 2;
  localparam int IC_TAG_W = 20;

  typedef logic [IC_TAG_W-1:0] ic_tag_t;
  typedef logic [IC_WAYS-1:0]  ic_tag_way_t;

  typedef struct packed {
    logic    valid;
    ic_tag_t tag;
`ifdef IC_TAG_PARITY_EN
    logic    par;
`endif
  } ic_tag_entry_t;

  // Even parity: stored bit makes {valid, tag, par} have an even popcount.
  function automatic logic ic_tag_par(input logic valid,
                                      input ic_tag_t tag);
    return ^{valid, tag};
  endfunction

endpackage

// File: rtl/ic_tag_way.sv
// ic_tag_way: one way of LINES tag entries, async write-first read port.
// Ports: clk; wr_en/wr_idx/wr_ent write; clr_en/clr_idx valid clear; rd_idx/rd_ent read.
module ic_tag_way
  import ic_pkg::*;
#(
  parameter  int LINES = 256,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  ic_tag_entry_t wr_ent,
  input  logic          clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output ic_tag_entry_t rd_ent
);

  // Tags (and parity) are never reset so they can map onto RAM.
  ic_tag_t          tag_mem [LINES];
`ifdef IC_TAG_PARITY_EN
  logic             par_mem [LINES];
`endif
  logic [LINES-1:0] vld;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_ent.tag;
`ifdef IC_TAG_PARITY_EN
      par_mem[wr_idx] <= wr_ent.par;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en)
      vld[clr_idx] <= 1'b0;
    else if (wr_en)
      vld[wr_idx] <= wr_ent.valid;
  end

  logic fwd;
  assign fwd = wr_en && (wr_idx == rd_idx);

  always_comb begin
    rd_ent.valid = vld[rd_idx];
    rd_ent.tag   = tag_mem[rd_idx];
`ifdef IC_TAG_PARITY_EN
    rd_ent.par   = par_mem[rd_idx];
`endif
    if (fwd)
      rd_ent = wr_ent;
  end

endmodule

// File: rtl/ic_tag_array.sv
// ic_tag_array: N-way icache tags, lookup/hit, victim select, flush sweep.
// Ports: clk, rst; lk_* lookup (1-cycle); wr_* refill; flush_req; busy. Macro: IC_TAG_PARITY_EN.
module ic_tag_array
  import ic_pkg::*;
#(
  parameter  int WAYS  = IC_WAYS,
  parameter  int LINES = 256,
  parameter  int TAG_W = IC_TAG_W,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_en,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [WAYS-1:0]  lk_hit_way,
  output logic [WAYS-1:0]  lk_victim,
  output logic             lk_par_err,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WAYS-1:0]  wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             flush_req,
  output logic             busy
);

  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, SWEEP} st_t;

  st_t              st, st_n;
  logic [IDX_W-1:0] cnt, cnt_n;

  assign busy = (st == SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= SWEEP;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    unique case (st)
      IDLE: begin
        if (flush_req) begin
          st_n  = SWEEP;
          cnt_n = '0;
        end
      end
      SWEEP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == IDX_W'(LINES - 1))
          st_n = IDLE;
      end
    endcase
  end

  logic          we;
  ic_tag_entry_t wr_ent;
  ic_tag_entry_t rd [WAYS];

  assign we = wr_en && !busy;

  always_comb begin
    wr_ent.valid = wr_valid;
    wr_ent.tag   = wr_tag;
`ifdef IC_TAG_PARITY_EN
    wr_ent.par   = ic_tag_par(wr_valid, wr_tag);
`endif
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ic_tag_way #(.LINES(LINES)) u_way (
      .clk    (clk),
      .wr_en  (we && wr_way[w]),
      .wr_idx (wr_idx),
      .wr_ent (wr_ent),
      .clr_en (busy),
      .clr_idx(cnt),
      .rd_idx (lk_idx),
      .rd_ent (rd[w])
    );
  end

  logic [WAYS-1:0] ok, hit, bad;

  // A way with broken parity is neither a hit nor a valid line.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
`ifdef IC_TAG_PARITY_EN
      bad[w] = rd[w].valid &&
               (rd[w].par != ic_tag_par(rd[w].valid, rd[w].tag));
`else
      bad[w] = 1'b0;
`endif
      ok[w]  = rd[w].valid && !bad[w];
      hit[w] = ok[w] && (rd[w].tag == lk_tag);
    end
  end

  logic [PTR_W-1:0] rr [LINES];
  logic [PTR_W-1:0] wi, ptr_wr, ptr_rd;
  logic             rr_we;

  always_comb begin
    wi = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (wr_way[w]) wi = PTR_W'(w);
  end

  assign ptr_wr = (WAYS == 1) ? '0 : wi + PTR_W'(1);
  assign rr_we  = we && wr_valid && (|wr_way);
  assign ptr_rd = (rr_we && (wr_idx == lk_idx)) ? ptr_wr : rr[lk_idx];

  always_ff @(posedge clk) begin
    if (busy)
      rr[cnt] <= '0;
    else if (rr_we)
      rr[wr_idx] <= ptr_wr;
  end

  logic [WAYS-1:0] vic;
  logic            found;

  always_comb begin
    vic   = '0;
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!ok[w] && !found) begin
        vic[w] = 1'b1;
        found  = 1'b1;
      end
    end
    if (!found)
      vic = WAYS'(1) << ptr_rd;
  end

  logic lk_act;
  assign lk_act = lk_en && !busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_hit     <= 1'b0;
      lk_hit_way <= '0;
      lk_victim  <= '0;
      lk_par_err <= 1'b0;
    end else begin
      lk_hit     <= lk_act && (|hit);
      lk_hit_way <= lk_act ? hit : '0;
      lk_victim  <= vic;
      lk_par_err <= lk_act && (|bad);
    end
  end

endmodule

// File: tb/tb_ic_tag_array.sv
// tb_ic_tag_array: directed scoreboard bench for ic_tag_array.
// Covers reset sweep, hit/miss, write-first, victim RR, flush, parity.
module tb_ic_tag_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lk_en = 1'b0;
  logic [7:0]  lk_idx = '0;
  logic [19:0] lk_tag = '0;
  logic        lk_hit;
  logic [1:0]  lk_hit_way;
  logic [1:0]  lk_victim;
  logic        lk_par_err;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_idx = '0;
  logic [1:0]  wr_way = '0;
  logic [19:0] wr_tag = '0;
  logic        wr_valid = 1'b0;
  logic        flush_req = 1'b0;
  logic        busy;

  ic_tag_array dut (
    .clk       (clk),
    .rst       (rst),
    .lk_en     (lk_en),
    .lk_idx    (lk_idx),
    .lk_tag    (lk_tag),
    .lk_hit    (lk_hit),
    .lk_hit_way(lk_hit_way),
    .lk_victim (lk_victim),
    .lk_par_err(lk_par_err),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_way    (wr_way),
    .wr_tag    (wr_tag),
    .wr_valid  (wr_valid),
    .flush_req (flush_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       hit;
    logic [1:0] hw;
    logic [1:0] vic;
    logic       cv;
    logic       par;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".hit"}, 32'(lk_hit), 32'(e.hit));
    chk({e.name, ".hit_way"}, 32'(lk_hit_way), 32'(e.hw));
    if (e.cv)
      chk({e.name, ".victim"}, 32'(lk_victim), 32'(e.vic));
    chk({e.name, ".par_err"}, 32'(lk_par_err), 32'(e.par));
    chk({e.name, ".onehot0"}, 32'($onehot0(lk_hit_way)), 32'd1);
  endtask

  task automatic push(input string nm, input logic h, input logic [1:0] hw,
                      input logic [1:0] v, input logic cv, input logic p);
    exp_t e;
    e.name = nm;
    e.hit  = h;
    e.hw   = hw;
    e.vic  = v;
    e.cv   = cv;
    e.par  = p;
    sb.push_back(e);
  endtask

  task automatic look(input string nm, input logic [7:0] idx,
                      input logic [19:0] tag, input logic h,
                      input logic [1:0] hw, input logic [1:0] v,
                      input logic p);
    lk_en  = 1'b1;
    lk_idx = idx;
    lk_tag = tag;
    push(nm, h, hw, v, 1'b1, p);
    tick();
    lk_en = 1'b0;
    check_out();
  endtask

  task automatic wr(input logic [7:0] idx, input logic [1:0] way,
                    input logic [19:0] tag, input logic v);
    wr_en    = 1'b1;
    wr_idx   = idx;
    wr_way   = way;
    wr_tag   = tag;
    wr_valid = v;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset and initial sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.hit", 32'(lk_hit), 32'd0);
    chk("rst.hit_way", 32'(lk_hit_way), 32'd0);
    chk("rst.victim", 32'(lk_victim), 32'd0);
    chk("rst.par_err", 32'(lk_par_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 600) begin
      tick();
      n++;
    end
    chk("rst.sweep_len", 32'(n), 32'd256);
    look("t1", 8'd0, 20'h0, 1'b0, 2'b00, 2'b01, 1'b0);

    // Basic write then hit / miss
    wr(8'd5, 2'b10, 20'h12345, 1'b1);
    look("t2.hit", 8'd5, 20'h12345, 1'b1, 2'b10, 2'b01, 1'b0);
    look("t2.miss", 8'd5, 20'h12344, 1'b0, 2'b00, 2'b01, 1'b0);

    // Write-first collision
    wr_en    = 1'b1;
    wr_idx   = 8'd7;
    wr_way   = 2'b01;
    wr_tag   = 20'hABCDE;
    wr_valid = 1'b1;
    lk_en    = 1'b1;
    lk_idx   = 8'd7;
    lk_tag   = 20'hABCDE;
    push("t3", 1'b1, 2'b01, 2'b10, 1'b1, 1'b0);
    tick();
    wr_en = 1'b0;
    lk_en = 1'b0;
    check_out();

    // Victim rotation
    wr(8'd9, 2'b01, 20'h0AAAA, 1'b1);
    look("t4.a", 8'd9, 20'h55555, 1'b0, 2'b00, 2'b10, 1'b0);
    wr(8'd9, 2'b10, 20'h0BBBB, 1'b1);
    look("t4.b", 8'd9, 20'h55555, 1'b0, 2'b00, 2'b01, 1'b0);
    look("t4.hit1", 8'd9, 20'h0BBBB, 1'b1, 2'b10, 2'b01, 1'b0);
    wr(8'd9, 2'b01, 20'h0CCCC, 1'b1);
    look("t4.c", 8'd9, 20'h55555, 1'b0, 2'b00, 2'b10, 1'b0);
    look("t4.hit0", 8'd9, 20'h0CCCC, 1'b1, 2'b01, 2'b10, 1'b0);
    wr(8'd4, 2'b00, 20'h00042, 1'b1);
    look("t4.nowr", 8'd4, 20'h00042, 1'b0, 2'b00, 2'b01, 1'b0);

    // Flush sweep
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("t5.busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 600) begin
      if (n == 3) begin
        lk_en  = 1'b1;
        lk_idx = 8'd5;
        lk_tag = 20'h12345;
        push("t5.busy_look", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      end
      if (n == 10) begin
        wr_en    = 1'b1;
        wr_idx   = 8'd5;
        wr_way   = 2'b01;
        wr_tag   = 20'h00777;
        wr_valid = 1'b1;
      end
      if (n == 100)
        flush_req = 1'b1;
      tick();
      n++;
      wr_en     = 1'b0;
      flush_req = 1'b0;
      if (lk_en) begin
        lk_en = 1'b0;
        check_out();
      end
    end
    chk("t5.sweep_len", 32'(n), 32'd256);
    look("t5.old", 8'd5, 20'h12345, 1'b0, 2'b00, 2'b01, 1'b0);
    look("t5.drop", 8'd5, 20'h00777, 1'b0, 2'b00, 2'b01, 1'b0);
    look("t5.rr", 8'd9, 20'h0CCCC, 1'b0, 2'b00, 2'b01, 1'b0);

`ifdef IC_TAG_PARITY_EN
    // Parity error injection
    wr(8'd3, 2'b01, 20'h00001, 1'b1);
    look("t6.pre", 8'd3, 20'h00001, 1'b1, 2'b01, 2'b10, 1'b0);
    dut.g_way[0].u_way.tag_mem[3] = dut.g_way[0].u_way.tag_mem[3] ^ 20'h1;
    look("t6.par", 8'd3, 20'h00001, 1'b0, 2'b00, 2'b01, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ic_tag_array.md
Name: ic_tag_array

Overview:
N-way set-associative instruction-cache tag array: per-way tag storage, valid bits, lookup comparison and victim selection in one block.
- Sits between the fetch pipeline (lookup port) and the refill engine (write port).
- Owns a line-sweeping invalidate engine used at reset and on a flush request.

Parameters:
WAYS, 2, number of ways (power of two, 1..8)
LINES, 256, sets per way (power of two)
TAG_W, 20, tag width in bits
IDX_W, $clog2(LINES), derived localparam, set index width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
lk_en  in  1  lookup request
lk_idx  in  IDX_W  lookup set index
lk_tag  in  TAG_W  lookup compare tag
lk_hit  out  1  lookup hit
lk_hit_way  out  WAYS  one-hot matching way
lk_victim  out  WAYS  one-hot way to fill on miss
lk_par_err  out  1  parity error on lookup (0 without macro)
wr_en  in  1  tag write
wr_idx  in  IDX_W  write set index
wr_way  in  WAYS  one-hot way select
wr_tag  in  TAG_W  tag to write
wr_valid  in  1  valid bit to write
flush_req  in  1  invalidate-all request (pulse)
busy  out  1  sweep in progress

Behaviour:
- Ports: one clock `clk`; reset `rst` is synchronous and active-high.
- Lookup latency is 1 cycle. All lk_* outputs are registered and reflect the lk_en cycle.
- lk_en=0 or busy=1 in a cycle: lk_hit, lk_hit_way and lk_par_err are 0 in the next cycle. lk_victim still updates from lk_idx.
- Hit on a way: valid && stored tag == lk_tag.
  - lk_hit = OR of all way hits; lk_hit_way = raw per-way hit vector.
  - Multiple hits are illegal; the bench asserts lk_hit_way is $onehot0.
- Victim selection:
  - Lowest-numbered invalid way in the set, if any.
  - Otherwise the set's round-robin pointer (one log2(WAYS)-bit counter per set).
  - WAYS=1: victim is always 1.
- Pointer update: a write with wr_valid=1 sets the set's pointer to (index of wr_way + 1) mod WAYS.
- Write with wr_en=1 and busy=0:
  - Updates tag and valid of every way selected in wr_way at wr_idx, visible from the next cycle.
  - wr_way=0 is a no-op.
- Collision (write-first): wr_en && lk_en with lk_idx == wr_idx in the same cycle means the lookup result and victim use the newly written contents. Same requirement for the parity check.
- Sweep FSM, states IDLE and SWEEP, with an IDX_W-bit line counter:
  - rst=1: next state SWEEP, counter 0.
  - IDLE, flush_req=1: SWEEP, counter 0.
  - SWEEP: clears valid of all ways and the RR pointer at the counter; counter+1. At LINES-1 the clear completes and the next state is IDLE.
  - busy = (state == SWEEP); the sweep takes exactly LINES cycles.
  - flush_req while busy is ignored.
  - rst mid-sweep restarts the sweep at line 0.
  - wr_en while busy is dropped. lk_en while busy returns a miss.
- Reset values (cycle after rst): lk_hit 0, lk_hit_way 0, lk_victim 0, lk_par_err 0, busy 1.
- Tag contents are not reset (BRAM-inferable). Valid bits and RR pointers are flops, cleared only by the sweep.

Optional Feature:
IC_TAG_PARITY_EN
- Defined:
  - Each entry stores an even-parity bit over {valid, tag}, written with the entry.
  - On lookup, a way with mismatched parity is forced non-hit and treated as invalid for victim selection.
  - lk_par_err=1 in the result cycle if any way mismatches (only when lk_en=1 and busy=0).
- Undefined: no parity storage; lk_par_err is tied 0.

Decomposition:
- ic_pkg gets:
  - ic_tag_t (TAG_W)
  - ic_tag_way_t (WAYS-wide one-hot)
  - ic_tag_entry_t packed {valid, tag[, parity]}
  - IC_WAYS, IC_TAG_W constants
  - parity function ic_tag_par()
- One sub-module, ic_tag_way: single-way LINES x entry storage with a write-first read port.
  - Instantiated WAYS times by a generate loop.
  - Compare, victim and sweep logic stay in ic_tag_array.

Test Plan:
1. Reset: rst high 1 cycle -> busy=1 for exactly 256 cycles, then 0. Lookup idx 0 tag 0 -> lk_hit=0, lk_victim=2'b01.
2. Write idx 5, way 2'b10, tag 0x12345, valid=1; lookup idx 5 tag 0x12345 next cycle -> lk_hit=1, lk_hit_way=2'b10. Tag 0x12344 -> lk_hit=0, lk_victim=2'b01.
3. Same-cycle write idx 7, way 2'b01, tag 0xABCDE, with lookup idx 7 tag 0xABCDE -> following cycle lk_hit=1, lk_hit_way=2'b01.
4. Victim rotation on idx 9:
   - Fill way0 -> lk_victim=2'b10.
   - Fill way1 -> lk_victim=2'b01 (pointer 0).
   - Refill way0 -> lk_victim=2'b10.
5. Flush: after test 2, pulse flush_req -> busy=1 from the next cycle for 256 cycles.
   - Write at cycle 10 of the sweep is dropped.
   - Lookups during the sweep miss.
   - After the sweep, idx 5 tag 0x12345 misses.
   - flush_req at cycle 100 does not extend busy.
6. (IC_TAG_PARITY_EN) Backdoor-flip tag bit 0 of idx 3 way0 (tag 0x00001) -> lookup idx 3 tag 0x00001 gives lk_hit=0, lk_par_err=1, lk_victim=2'b01.
